vector_norm_engine: RTL

VECTOR_NORM_ENGINE -- requirements
Module: vector_norm_engine

---
 rtl/norm_pkg.sv | 16 +
 rtl/sq_accum.sv | 66 ++++++
 rtl/vector_norm_engine.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/norm_pkg.sv
// Shared definitions for the linked-list vector norm engine: traversal states
// and the node layout offsets.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ELEM = 2'd1,
    NEXT = 2'd2,
    FIN  = 2'd3
  } norm_state_e;

  localparam int NULL_PTR = 0;
  localparam int PTR_OFS  = 0;
  localparam int ELEM_OFS = 2;

endpackage

// File: rtl/sq_accum.sv
// Squares a signed element and accumulates it into an unsigned, saturating
// sum with a sticky overflow flag.
module sq_accum
  import norm_pkg::*;
#(
  parameter int WORD_W = 24,
  parameter int ACC_W  = 56
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [WORD_W-1:0] din,
  output logic [ACC_W-1:0]         acc,
  output logic                     ovf
);

  localparam int PROD_W = 2 * WORD_W;
  // One guard bit above the wider of accumulator and square catches any carry-out.
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  logic signed [PROD_W-1:0] din_x;
  logic signed [PROD_W-1:0] din_sq;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     ovf_q, ovf_d;

  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  a,
                                             input logic [PROD_W-1:0] p,
                                             input logic              sticky);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(p);
    if (sticky || (|s[SUM_W-1:ACC_W])) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  assign din_x  = PROD_W'(din);
  assign din_sq = din_x * din_x;

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      {ovf_d, acc_d} = sat_add(acc_q, din_sq, ovf_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/vector_norm_engine.sv
// Walks a linked list of fixed-size vector nodes in memory, accumulating the
// sum of squares of every element and counting the nodes visited.
module vector_norm_engine
  import norm_pkg::*;
#(
  parameter int WORD_W = 24,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8,
  parameter int ELEMS  = 2,
  parameter int ACC_W  = 56
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        head,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_valid,
  input  logic signed [WORD_W-1:0] rd_data,
  output logic [ACC_W-1:0]         sum_sq,
  output logic [LEN_W-1:0]         len,
  output logic                     ovf,
  output logic                     err_len
);

  norm_state_e       state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [3:0]        idx_q;
  logic [LEN_W-1:0]  len_q;
  logic              rd_req_q;
  logic              done_q;
  logic              err_len_q;

  logic              accept;
  logic              rd_done;
  logic              acc_en;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  len_inc;

  assign accept  = (state_q == IDLE) && start;
  assign rd_done = rd_req_q && rd_valid;
  assign acc_en  = (state_q == ELEM) && rd_done;
  assign ptr     = rd_data[ADDR_W-1:0];
  assign len_inc = len_q + LEN_W'(1);

  sq_accum #(
    .WORD_W (WORD_W),
    .ACC_W  (ACC_W)
  ) u_sq_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (acc_en),
    .din   (rd_data),
    .acc   (sum_sq),
    .ovf   (ovf)
  );

  // rd_req stays high through ELEM and NEXT; the address advances on each
  // completion so the next read is presented on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      rd_addr_q <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      rd_req_q  <= 1'b0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q    <= head;
            idx_q     <= '0;
            len_q     <= '0;
            err_len_q <= 1'b0;
            if (head == ADDR_W'(NULL_PTR)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ELEM;
              rd_req_q  <= 1'b1;
              rd_addr_q <= head + ADDR_W'(ELEM_OFS);
            end
          end
        end
        ELEM: begin
          if (rd_done) begin
            if (idx_q == 4'(ELEMS - 1)) begin
              state_q   <= NEXT;
              rd_addr_q <= base_q + ADDR_W'(PTR_OFS);
            end else begin
              idx_q     <= idx_q + 4'd1;
              rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
          end
        end
        NEXT: begin
          if (rd_done) begin
            len_q <= len_inc;
            if (ptr == ADDR_W'(NULL_PTR)) begin
              state_q  <= FIN;
              rd_req_q <= 1'b0;
              done_q   <= 1'b1;
            end else if (len_inc == '1) begin
              state_q   <= FIN;
              rd_req_q  <= 1'b0;
              done_q    <= 1'b1;
              err_len_q <= 1'b1;
            end else begin
              state_q   <= ELEM;
              base_q    <= ptr;
              idx_q     <= '0;
              rd_addr_q <= ptr + ADDR_W'(ELEM_OFS);
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign len     = len_q;
  assign err_len = err_len_q;

endmodule
